// File: rtl/tail_light_seq_ctrl.sv
// Tail-light sequencing controller: arbitrates turn/hazard/brake requests and
// steps a three-lamp-per-side pattern at a DIV-cycle rate with registered lamps.
module tail_light_seq_ctrl #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] lamp_l,
  output logic [2:0] lamp_r,
  output logic       step,
  output logic       busy
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_L3,
    S_R1,
    S_R2,
    S_R3,
    S_HAZ,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    lamp_l_q, lamp_l_d;
  logic [2:0]    lamp_r_q, lamp_r_d;
  logic          busy_q, busy_d;
  logic          req;
  state_t        disp_st;

  assign step   = (state_q != S_IDLE) && (cnt_q == CNT_MAX);
  assign lamp_l = lamp_l_q;
  assign lamp_r = lamp_r_q;
  assign busy   = busy_q;

  // Dispatch target; left and right together are treated as hazard.
  always_comb begin
    req     = hazard | left | right;
    disp_st = S_R1;
    if (hazard || (left && right)) disp_st = S_HAZ;
    else if (left)                 disp_st = S_L1;
  end

  // Next state and prescaler.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req)  state_d = disp_st;
      S_L1:   if (step) state_d = hazard ? S_HAZ : S_L2;
      S_L2:   if (step) state_d = hazard ? S_HAZ : S_L3;
      S_L3:   if (step) state_d = hazard ? S_HAZ : S_GAP;
      S_R1:   if (step) state_d = hazard ? S_HAZ : S_R2;
      S_R2:   if (step) state_d = hazard ? S_HAZ : S_R3;
      S_R3:   if (step) state_d = hazard ? S_HAZ : S_GAP;
      S_HAZ:  if (step) state_d = S_GAP;
      S_GAP:  if (step) state_d = req ? disp_st : S_IDLE;
      default:          state_d = S_IDLE;
    endcase
    if (state_q == S_IDLE || step) cnt_d = '0;
    else                           cnt_d = cnt_q + CW'(1);
  end

  // Lamp patterns follow the next state, with the brake overlay applied.
  always_comb begin
    lamp_l_d = 3'b000;
    lamp_r_d = 3'b000;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_L1:  lamp_l_d = 3'b001;
      S_L2:  lamp_l_d = 3'b011;
      S_L3:  lamp_l_d = 3'b111;
      S_R1:  lamp_r_d = 3'b001;
      S_R2:  lamp_r_d = 3'b011;
      S_R3:  lamp_r_d = 3'b111;
      S_HAZ: begin
        lamp_l_d = 3'b111;
        lamp_r_d = 3'b111;
      end
      default: ;
    endcase
    if (brake) begin
      case (state_d)
        S_IDLE, S_GAP: begin
          lamp_l_d = 3'b111;
          lamp_r_d = 3'b111;
        end
        S_L1, S_L2, S_L3: lamp_r_d = 3'b111;
        S_R1, S_R2, S_R3: lamp_l_d = 3'b111;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lamp_l_q <= 3'b000;
      lamp_r_q <= 3'b000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lamp_l_q <= lamp_l_d;
      lamp_r_q <= lamp_r_d;
      busy_q   <= busy_d;
    end
  end

endmodule
